// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Latency: MULT_CYCLES / DIV_CYCLES cycles of busy before HI/LO commit; MTHI/MTLO take one edge.
// Backpressure: busy high while an op is in flight; starts seen while busy are dropped.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [31:0]   hi_d, lo_d;
    logic [31:0]   sh_hi, sh_lo, sh_hi_d, sh_lo_d;
    logic          sh_wr, sh_wr_d;

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic               div_signed;
    logic [31:0]        a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;

    // Signed divide runs on magnitudes so 0x80000000 / -1 falls out as 0x80000000 without overflow.
    always_comb begin
        prod_s     = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        prod_u     = {32'd0, a} * {32'd0, b};
        div_signed = ~op[0];
        a_mag      = (div_signed && a[31]) ? (32'd0 - a) : a;
        b_mag      = (div_signed && b[31]) ? (32'd0 - b) : b;
        b_safe     = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag      = a_mag / b_safe;
        r_mag      = a_mag % b_safe;
        quo        = (div_signed && (a[31] ^ b[31])) ? (32'd0 - q_mag) : q_mag;
        rem        = (div_signed && a[31]) ? (32'd0 - r_mag) : r_mag;
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        hi_d    = hi;
        lo_d    = lo;
        sh_hi_d = sh_hi;
        sh_lo_d = sh_lo;
        sh_wr_d = sh_wr;
        case (state)
            IDLE: begin
                if (start) begin
                    case (op)
                        3'd0: begin
                            {sh_hi_d, sh_lo_d} = prod_s;
                            sh_wr_d = 1'b1;
                            cnt_d   = CW'(MULT_CYCLES);
                            state_d = RUN;
                        end
                        3'd1: begin
                            {sh_hi_d, sh_lo_d} = prod_u;
                            sh_wr_d = 1'b1;
                            cnt_d   = CW'(MULT_CYCLES);
                            state_d = RUN;
                        end
                        3'd2, 3'd3: begin
                            sh_hi_d = rem;
                            sh_lo_d = quo;
                            // Divide by zero still spends the full busy period but never commits.
                            sh_wr_d = (b != 32'd0);
                            cnt_d   = CW'(DIV_CYCLES);
                            state_d = RUN;
                        end
                        3'd4:    hi_d = a;
                        3'd5:    lo_d = a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_d = IDLE;
                    if (sh_wr) begin
                        hi_d = sh_hi;
                        lo_d = sh_lo;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            sh_hi <= 32'd0;
            sh_lo <= 32'd0;
            sh_wr <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            hi    <= hi_d;
            lo    <= lo_d;
            sh_hi <= sh_hi_d;
            sh_lo <= sh_lo_d;
            sh_wr <= sh_wr_d;
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_mdu.sv
// Bench for mdu: directed and random ops against a plain-arithmetic HI/LO model.
module tb_mdu;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy;
    logic [31:0] hi, lo;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mhi = 32'd0;
    logic [31:0] mlo = 32'd0;

    mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint          sx, sy;
        longint unsigned ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            3'd0: {mhi, mlo} = 64'(sx * sy);
            3'd1: {mhi, mlo} = ux * uy;
            3'd2: if (y != 32'd0) begin mlo = 32'(sx / sy); mhi = 32'(sx % sy); end
            3'd3: if (y != 32'd0) begin mlo = 32'(ux / uy); mhi = 32'(ux % uy); end
            3'd4: mhi = x;
            3'd5: mlo = x;
            default: ;
        endcase
    endtask

    // Called at a negedge with busy low; returns at the first negedge with busy low again.
    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input bit poke);
        logic [31:0] ph, pl;
        int          n, expn;
        ph   = mhi;
        pl   = mlo;
        expn = (o < 3'd2) ? MC : (o < 3'd4) ? DC : 0;
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            if (n == 1) begin
                check({tag, " hi during run"}, hi, ph);
                check({tag, " lo during run"}, lo, pl);
            end
            // A start raised mid-operation must be dropped.
            start = poke && (n == 3);
            op    = 3'd0;
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, " busy cycles"}, n, expn);
        model(o, x, y);
        check({tag, " hi"}, hi, mhi);
        check({tag, " lo"}, lo, mlo);
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset busy", busy, 1'b0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);

        do_op("mult", 3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
        check("mult hi const", hi, 32'hFFFF_FFFF);
        check("mult lo const", lo, 32'hFFFF_FFFA);
        do_op("multu", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("multu hi const", hi, 32'hFFFF_FFFE);
        check("multu lo const", lo, 32'h0000_0001);
        do_op("div", 3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        check("div lo const", lo, 32'hFFFF_FFFD);
        check("div hi const", hi, 32'hFFFF_FFFF);

        do_op("mthi pre", 3'd4, 32'h11, 32'h0, 1'b0);
        do_op("mtlo pre", 3'd5, 32'h22, 32'h0, 1'b0);
        do_op("divu by0", 3'd3, 32'd7, 32'd0, 1'b0);
        check("divu by0 hi const", hi, 32'h11);
        check("divu by0 lo const", lo, 32'h22);

        do_op("div ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        check("div ovf lo const", lo, 32'h8000_0000);
        check("div ovf hi const", hi, 32'h0);
        // Issued on the first idle cycle: back-to-back acceptance.
        do_op("b2b multu", 3'd1, 32'd12345, 32'd678, 1'b0);

        do_op("mthi", 3'd4, 32'h1234_5678, 32'h0, 1'b0);
        check("mthi hi const", hi, 32'h1234_5678);
        do_op("mtlo", 3'd5, 32'h9ABC_DEF0, 32'h0, 1'b0);
        check("mtlo lo const", lo, 32'h9ABC_DEF0);
        check("mtlo hi kept", hi, 32'h1234_5678);
        do_op("rsvd6", 3'd6, 32'hDEAD_BEEF, 32'h1, 1'b0);
        do_op("rsvd7", 3'd7, 32'hDEAD_BEEF, 32'h1, 1'b0);

        for (int i = 0; i < 30; i++) begin
            logic [2:0]  ro;
            logic [31:0] ra, rb;
            ro = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 :
                 ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom;
            do_op("random", ro, ra, rb, i[0]);
        end

        // Abort a multiply at its third busy cycle, with a start held during reset.
        start = 1'b1; op = 3'd0; a = 32'd1000; b = 32'd1000;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (n < 3) begin @(negedge clk); n++; end
        check("abort busy before reset", busy, 1'b1);
        reset = 1'b1; start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        mhi = 32'd0; mlo = 32'd0;
        check("abort busy", busy, 1'b0);
        check("abort hi", hi, mhi);
        check("abort lo", lo, mlo);
        repeat (MC + 3) @(negedge clk);
        check("abort no commit busy", busy, 1'b0);
        check("abort no commit hi", hi, 32'd0);
        check("abort no commit lo", lo, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
- Sits in the execute stage, directly downstream of the general-purpose register file; its a/b operands come from register-file read data rs/rt.
- hi/lo feed back through the execute result mux for MFHI/MFLO.
- Control stalls the pipeline while busy is high.

Parameters:
- MULT_CYCLES, 5, cycles from accepted MULT/MULTU to HI/LO commit (legal range >= 1).
- DIV_CYCLES, 10, cycles from accepted DIV/DIVU to HI/LO commit (legal range >= 1).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to execute op this cycle.
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7 reserved.
- a  input  32  operand rs (dividend / multiplicand / MTHI-MTLO data).
- b  input  32  operand rt (divisor / multiplier).
- busy  output  1  operation in flight; HI/LO not yet valid.
- hi  output  32  HI register, driven directly from flop.
- lo  output  32  LO register, driven directly from flop.

Behaviour:
- Reset: busy=0, hi=0, lo=0, counter=0, pending result discarded. Reset overrides start.
- Reset mid-operation aborts the operation. No commit ever occurs for the aborted op.
- States: IDLE, RUN.
- Start acceptance:
  - start is accepted only in IDLE. start while busy=1 is ignored entirely, with no queuing.
  - Control must not assert start while busy.
- IDLE with start and op 0-3:
  - Capture the result into shadow registers.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN; busy=1 from the next cycle.
- Commit timing:
  - Counter decrements each RUN cycle.
  - On the edge where counter reaches 0, hi/lo take the shadow values, busy goes to 0, and the state returns to IDLE.
  - busy is high for exactly N cycles; hi/lo change on the same edge that busy falls.
  - A new start is accepted on the first cycle busy=0 (back-to-back throughput = N+1 cycles).
- IDLE with start and op=4 (MTHI): hi<=a at the next edge; lo unchanged; busy stays 0.
- IDLE with start and op=5 (MTLO): lo<=a at the next edge; hi unchanged; busy stays 0.
- op 6/7 with start: no effect.
- Arithmetic:
  - MULT: 64-bit signed product of a, b. hi=product[63:32], lo=product[31:0].
  - MULTU: same split, unsigned product.
  - DIV (signed): lo=quotient truncated toward zero; hi=remainder, with the sign of the dividend (a).
  - DIVU: unsigned quotient to lo, remainder to hi.
  - DIV of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0. No trap.
  - Divide by zero (b=0, DIV or DIVU): full DIV_CYCLES busy period; at commit, hi and lo are left unchanged.
- Operand capture: a/b are sampled only at the accept edge. Changes on a/b during RUN have no effect.
- Reading hi/lo during RUN returns the pre-operation values.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=0x00000003:
  - busy high 5 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF: after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=0x00000002:
  - busy high 10 cycles.
  - Then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU a=7, b=0 with preloaded hi=0x11, lo=0x22: busy 10 cycles, then hi=0x11, lo=0x22.
- DIV a=0x80000000, b=0xFFFFFFFF:
  - lo=0x80000000, hi=0.
  - A second start asserted during busy is ignored; a start on the first busy=0 cycle is accepted.
- MTHI a=0x12345678, then MTLO a=0x9ABCDEF0:
  - busy never asserts.
  - hi/lo update one cycle after each start.
- Start MULT, assert reset at RUN cycle 3: busy=0, hi=0, lo=0 next edge; no later commit.
